stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_sequencer_if.sv | 38 +++
 rtl/stack_sequencer.sv | 172 +++++++++++++++++
 tb/tb_stack_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_sequencer_if
// Description : Handshake/bus bundle between an instruction sequencer front end
//               (master) and the stack sequencer (slave).
//   Ports (master -> slave): start, push_mask, pop_mask, sp_in, req_ready
//   Ports (slave -> master): busy, req_valid, req_write, req_reg, req_addr,
//                            sp_out, sp_we, done
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_sequencer_if #(
    parameter int MASK_W = 16
);
    logic              start;
    logic [MASK_W-1:0] push_mask;
    logic [MASK_W-1:0] pop_mask;
    logic [15:0]       sp_in;
    logic              busy;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [3:0]        req_reg;
    logic [15:0]       req_addr;
    logic [15:0]       sp_out;
    logic              sp_we;
    logic              done;

    modport master (
        output start, push_mask, pop_mask, sp_in, req_ready,
        input  busy, req_valid, req_write, req_reg, req_addr, sp_out, sp_we, done
    );

    modport slave (
        input  start, push_mask, pop_mask, sp_in, req_ready,
        output busy, req_valid, req_write, req_reg, req_addr, sp_out, sp_we, done
    );
endinterface
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stack_sequencer
// Description : Turns a decoded instruction's push/pop register masks into a
//               sequence of one-word stack bus transfers and reports the final
//               stack pointer. Pushes go lowest bit first with pre-decrement,
//               pops go highest bit first with post-increment; pop bit 5
//               (BP_SKIP_SP) only advances SP.
//   clk, reset : clock, synchronous active-high reset
//   bus        : stack_sequencer_if.slave (start/masks/sp_in in; request
//                handshake, busy, done, sp_out/sp_we out)
// Revision    : 1.0 - initial release
// ============================================================================
module stack_sequencer #(
    parameter int MASK_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    stack_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_POP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int                c_SKIP_BIT  = 5;
    localparam logic [3:0]        c_SKIP_IDX  = 4'd5;
    localparam logic [MASK_W-1:0] c_SKIP_MASK = MASK_W'(1) << c_SKIP_BIT;

    state_t            state_q, state_d;
    logic [MASK_W-1:0] push_q, push_d;
    logic [MASK_W-1:0] pop_q, pop_d;
    logic [15:0]       sp_q, sp_d;

    logic              req_valid_q;
    logic              req_write_q;
    logic [3:0]        req_reg_q;
    logic [15:0]       req_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              sp_we_q;
    logic [15:0]       sp_out_q;

    logic              w_hs;
    logic [3:0]        w_push_idx;
    logic [3:0]        w_pop_idx;
    logic [3:0]        w_nxt_push_idx;
    logic [3:0]        w_nxt_pop_idx;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [3:0] lo_idx(input logic [MASK_W-1:0] m);
        lo_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (m[i]) lo_idx = 4'(i);
        end
    endfunction

    // Index of the highest set bit (0 when the mask is empty).
    function automatic logic [3:0] hi_idx(input logic [MASK_W-1:0] m);
        hi_idx = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (m[i]) hi_idx = 4'(i);
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        push_d     = push_q;
        pop_d      = pop_q;
        sp_d       = sp_q;
        w_hs       = req_valid_q & bus.req_ready;
        w_push_idx = lo_idx(push_q);
        w_pop_idx  = hi_idx(pop_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Push bit 5 never produces traffic, so drop it up front.
                    push_d = bus.push_mask & ~c_SKIP_MASK;
                    pop_d  = bus.pop_mask;
                    sp_d   = bus.sp_in;
                    if (push_d != '0)     state_d = S_PUSH;
                    else if (pop_d != '0) state_d = S_POP;
                    else                  state_d = S_DONE;
                end
            end
            S_PUSH: begin
                if (w_hs) begin
                    sp_d   = sp_q - 16'd2;
                    push_d = push_q & ~(MASK_W'(1) << w_push_idx);
                    if (push_d == '0) state_d = (pop_q != '0) ? S_POP : S_DONE;
                end
            end
            S_POP: begin
                // The skip bit has no request, so it retires without a handshake.
                if (w_hs || (w_pop_idx == c_SKIP_IDX)) begin
                    sp_d  = sp_q + 16'd2;
                    pop_d = pop_q & ~(MASK_W'(1) << w_pop_idx);
                    if (pop_d == '0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                push_d  = '0;
                pop_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        w_nxt_push_idx = lo_idx(push_d);
        w_nxt_pop_idx  = hi_idx(pop_d);
    end

    // Outputs are registered from the next-state values so each request is
    // presented in the cycle right after the decision that produced it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            push_q      <= '0;
            pop_q       <= '0;
            sp_q        <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_reg_q   <= '0;
            req_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sp_we_q     <= 1'b0;
            sp_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            sp_q        <= sp_d;
            req_valid_q <= (state_d == S_PUSH) ||
                           ((state_d == S_POP) && (w_nxt_pop_idx != c_SKIP_IDX));
            req_write_q <= (state_d == S_PUSH);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            sp_we_q     <= (state_d == S_DONE);
            if (state_d == S_DONE) sp_out_q <= sp_d;
            case (state_d)
                S_PUSH: begin
                    req_reg_q  <= w_nxt_push_idx;
                    req_addr_q <= sp_d - 16'd2;
                end
                S_POP: begin
                    req_reg_q  <= w_nxt_pop_idx;
                    req_addr_q <= sp_d;
                end
                default: begin
                    req_reg_q  <= '0;
                    req_addr_q <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_write = req_write_q;
    assign bus.req_reg   = req_reg_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.sp_out    = sp_out_q;
    assign bus.sp_we     = sp_we_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_sequencer
// Description : Self-checking bench for stack_sequencer. Directed scenarios plus
//               randomized masks/SP/backpressure against a list-based model of
//               the expected transfer sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_sequencer;
    localparam int MASK_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_sequencer_if #(.MASK_W(MASK_W)) bus ();

    stack_sequencer #(.MASK_W(MASK_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Transfers packed as {write, reg[3:0], addr[15:0]}.
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];

    // Expected transfer list and final SP, straight from the ordering rules.
    task automatic build_model(input logic [15:0] push, input logic [15:0] pop,
                               input logic [15:0] sp_i, output logic [15:0] sp_f,
                               output int n_items);
        logic [15:0] sp;
        sp = sp_i;
        n_items = 0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (push[i] && i != 5) begin
                sp = sp - 16'd2;
                exp_q.push_back({1'b1, 4'(i), sp});
                n_items++;
            end
        end
        for (int i = 15; i >= 0; i--) begin
            if (pop[i]) begin
                if (i != 5) exp_q.push_back({1'b0, 4'(i), sp});
                sp = sp + 16'd2;
                n_items++;
            end
        end
        sp_f = sp;
    endtask

    // Drives one operation from a negedge with the DUT idle and records what it
    // does. Returns at the negedge of the idle cycle after DONE.
    task automatic run_op(input logic [15:0] push, input logic [15:0] pop,
                          input logic [15:0] sp, input int pct, input int hold_low,
                          input bit spam, output int cyc, output logic [15:0] spo,
                          output int perr, output int skips, output int nvalid,
                          output bit tmo, output bit post_ok);
        bit          stalled;
        logic [20:0] pf;
        stalled = 1'b0;
        pf      = '0;
        obs_q.delete();
        cyc = 0; spo = '0; perr = 0; skips = 0; nvalid = 0; tmo = 1'b1; post_ok = 1'b0;
        bus.start     = 1'b1;
        bus.push_mask = push;
        bus.pop_mask  = pop;
        bus.sp_in     = sp;
        bus.req_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (spam) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.push_mask = 16'($urandom);
                bus.pop_mask  = 16'($urandom);
                bus.sp_in     = 16'($urandom);
            end
            if (c <= hold_low) bus.req_ready = 1'b0;
            else               bus.req_ready = ($urandom_range(1, 100) <= pct);
            if (stalled && (!bus.req_valid ||
                {bus.req_write, bus.req_reg, bus.req_addr} !== pf)) perr++;
            if (!bus.busy) perr++;
            if (bus.req_valid) nvalid++;
            if (bus.busy && !bus.req_valid && !bus.done) skips++;
            if (bus.done) begin
                cyc = c;
                spo = bus.sp_out;
                if (!bus.sp_we) perr++;
                tmo = 1'b0;
                break;
            end
            if (bus.req_valid && bus.req_ready)
                obs_q.push_back({bus.req_write, bus.req_reg, bus.req_addr});
            stalled = bus.req_valid && !bus.req_ready;
            pf      = {bus.req_write, bus.req_reg, bus.req_addr};
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.req_ready = 1'b0;
        if (!tmo) begin
            @(negedge clk);
            post_ok = !bus.done && !bus.busy && !bus.req_valid && !bus.sp_we;
        end
    endtask

    task automatic test_reset();
        logic [54:0] outs;
        reset = 1'b1;
        bus.start = 1'b1; bus.push_mask = 16'hFFFF; bus.pop_mask = 16'hFFFF;
        bus.sp_in = 16'h1234; bus.req_ready = 1'b1;
        repeat (3) @(negedge clk);
        outs = {bus.req_valid, bus.done, bus.sp_we, bus.busy, bus.req_write,
                bus.req_reg, bus.req_addr, bus.sp_out};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        reset = 1'b0; bus.start = 1'b0; bus.req_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.req_valid, bus.done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_start_ignored: got %b want 000",
                               {bus.busy, bus.req_valid, bus.done});
        end
    endtask

    task automatic test_push();
        int cyc, perr, skips, nv, bad; logic [15:0] spo; bit tmo, pok;
        run_op(16'h0003, 16'h0000, 16'h0100, 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        exp_q.delete();
        exp_q.push_back({1'b1, 4'd0, 16'h00FE});
        exp_q.push_back({1'b1, 4'd1, 16'h00FC});
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL push_seq: got %0d transfers (%0d differ) want %0d", obs_q.size(), bad, exp_q.size()); end
        n_cmp++; if (spo !== 16'h00FC) begin n_fail++; $display("FAIL push_sp: got %h want 00fc", spo); end
        n_cmp++; if (cyc != 3) begin n_fail++; $display("FAIL push_done_cycle: got %0d want 3", cyc); end
        n_cmp++; if (tmo || !pok || perr != 0) begin n_fail++; $display("FAIL push_protocol: tmo=%0d post_ok=%0d perr=%0d want 0/1/0", tmo, pok, perr); end
    endtask

    task automatic test_pop();
        int cyc, perr, skips, nv, bad; logic [15:0] spo; bit tmo, pok;
        run_op(16'h0000, 16'h0C00, 16'h0200, 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        exp_q.delete();
        exp_q.push_back({1'b0, 4'd11, 16'h0200});
        exp_q.push_back({1'b0, 4'd10, 16'h0202});
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL pop_seq: got %0d transfers (%0d differ) want %0d", obs_q.size(), bad, exp_q.size()); end
        n_cmp++; if (spo !== 16'h0204) begin n_fail++; $display("FAIL pop_sp: got %h want 0204", spo); end
        n_cmp++; if (tmo || !pok || perr != 0) begin n_fail++; $display("FAIL pop_protocol: tmo=%0d post_ok=%0d perr=%0d want 0/1/0", tmo, pok, perr); end
    endtask

    task automatic test_skip();
        int cyc, perr, skips, nv, bad; logic [15:0] spo; bit tmo, pok;
        run_op(16'h0000, 16'h0061, 16'h0100, 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        exp_q.delete();
        exp_q.push_back({1'b0, 4'd6, 16'h0100});
        exp_q.push_back({1'b0, 4'd0, 16'h0104});
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL skip_seq: got %0d transfers (%0d differ) want %0d", obs_q.size(), bad, exp_q.size()); end
        n_cmp++; if (spo !== 16'h0106) begin n_fail++; $display("FAIL skip_sp: got %h want 0106", spo); end
        n_cmp++; if (skips != 1) begin n_fail++; $display("FAIL skip_idle_cycles: got %0d want 1", skips); end
        n_cmp++; if (cyc != 4) begin n_fail++; $display("FAIL skip_done_cycle: got %0d want 4", cyc); end
    endtask

    task automatic test_backpressure();
        int cyc, perr, skips, nv, bad; logic [15:0] spo; bit tmo, pok;
        run_op(16'h4000, 16'h0000, 16'h0000, 100, 3, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        exp_q.delete();
        exp_q.push_back({1'b1, 4'd14, 16'hFFFE});
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_seq: got %0d transfers (%0d differ) want %0d", obs_q.size(), bad, exp_q.size()); end
        n_cmp++; if (nv != 4) begin n_fail++; $display("FAIL bp_valid_cycles: got %0d want 4", nv); end
        n_cmp++; if (perr != 0) begin n_fail++; $display("FAIL bp_stability: got %0d violations want 0", perr); end
        n_cmp++; if (spo !== 16'hFFFE || cyc != 5) begin n_fail++; $display("FAIL bp_done: got sp %h cyc %0d want fffe cyc 5", spo, cyc); end
    endtask

    task automatic test_combined();
        int cyc, perr, skips, nv, bad; logic [15:0] spo; bit tmo, pok;
        run_op(16'h4000, 16'h0001, 16'h0010, 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        exp_q.delete();
        exp_q.push_back({1'b1, 4'd14, 16'h000E});
        exp_q.push_back({1'b0, 4'd0, 16'h000E});
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL comb_seq: got %0d transfers (%0d differ) want %0d", obs_q.size(), bad, exp_q.size()); end
        n_cmp++; if (spo !== 16'h0010) begin n_fail++; $display("FAIL comb_sp: got %h want 0010", spo); end
    endtask

    task automatic test_empty_and_wrap();
        int cyc, perr, skips, nv; logic [15:0] spo; bit tmo, pok;
        // Push bit 5 is discarded, so this mask is effectively empty.
        run_op(16'h0020, 16'h0000, 16'hBEEF, 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        n_cmp++; if (cyc != 1 || spo !== 16'hBEEF || obs_q.size() != 0) begin n_fail++; $display("FAIL empty_done: got cyc %0d sp %h n %0d want 1 beef 0", cyc, spo, obs_q.size()); end
        n_cmp++; if (!pok) begin n_fail++; $display("FAIL empty_one_cycle_done: got post_ok 0 want 1"); end
        run_op(16'h0000, 16'h0001, 16'hFFFE, 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        n_cmp++; if (obs_q.size() != 1 || spo !== 16'h0000) begin n_fail++; $display("FAIL pop_wrap: got n %0d sp %h want 1 0000", obs_q.size(), spo); end
        else begin
            n_cmp++; if (obs_q[0] !== {1'b0, 4'd0, 16'hFFFE}) begin n_fail++; $display("FAIL pop_wrap_req: got %h want %h", obs_q[0], {1'b0, 4'd0, 16'hFFFE}); end
        end
    endtask

    task automatic test_reset_midop();
        int cyc, perr, skips, nv, bad, n_it, stray; logic [15:0] spo, spf; bit tmo, pok;
        logic [54:0] outs;
        bus.start = 1'b1; bus.push_mask = 16'h00FF; bus.pop_mask = 16'h0000;
        bus.sp_in = 16'h1000; bus.req_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1; bus.push_mask = 16'h0001; bus.pop_mask = 16'h0001;
        @(negedge clk);
        outs = {bus.req_valid, bus.done, bus.sp_we, bus.busy, bus.req_write,
                bus.req_reg, bus.req_addr, bus.sp_out};
        n_cmp++; if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", outs); end
        reset = 1'b0; bus.start = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.req_valid || bus.busy) stray++;
        end
        n_cmp++; if (stray != 0) begin n_fail++; $display("FAIL midreset_no_requests: got %0d busy cycles want 0", stray); end
        build_model(16'h00FF, 16'h0000, 16'h1000, spf, n_it);
        run_op(16'h00FF, 16'h0000, 16'h1000, 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad != 0 || spo !== spf) begin n_fail++; $display("FAIL midreset_restart: got %0d transfers (%0d differ) sp %h want %0d sp %h", obs_q.size(), bad, spo, exp_q.size(), spf); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pv[3] = '{16'h0003, 16'h0000, 16'h8000};
        logic [15:0] qv[3] = '{16'h0000, 16'h0C00, 16'h0021};
        logic [15:0] sv[3] = '{16'h0100, 16'h0200, 16'h0002};
        int cyc, perr, skips, nv, bad, n_it; logic [15:0] spo, spf; bit tmo, pok;
        for (int k = 0; k < 3; k++) begin
            build_model(pv[k], qv[k], sv[k], spf, n_it);
            run_op(pv[k], qv[k], sv[k], 100, 0, 1'b0, cyc, spo, perr, skips, nv, tmo, pok);
            bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
            if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
            n_cmp++; if (bad != 0 || spo !== spf) begin n_fail++; $display("FAIL b2b_%0d_seq: got %0d transfers (%0d differ) sp %h want %0d sp %h", k, obs_q.size(), bad, spo, exp_q.size(), spf); end
            n_cmp++; if (cyc != 1 + n_it) begin n_fail++; $display("FAIL b2b_%0d_latency: got %0d want %0d", k, cyc, 1 + n_it); end
        end
    endtask

    task automatic test_random();
        int cyc, perr, skips, nv, bad, n_it; logic [15:0] spo, spf, p, q, s; bit tmo, pok;
        for (int k = 0; k < 40; k++) begin
            p = 16'($urandom & $urandom);
            q = 16'($urandom & $urandom);
            if (k % 4 == 0) q[5] = 1'b1;
            s = (k % 5 == 0) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            if (k % 7 == 0) s = 16'hFFFE;
            build_model(p, q, s, spf, n_it);
            run_op(p, q, s, $urandom_range(30, 100), 0, k[0], cyc, spo, perr, skips, nv, tmo, pok);
            bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
            if (bad == 0) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
            n_cmp++; if (bad != 0 || tmo) begin n_fail++; $display("FAIL rand_%0d_seq: push %h pop %h sp %h got %0d transfers (%0d differ) tmo %0d want %0d", k, p, q, s, obs_q.size(), bad, tmo, exp_q.size()); end
            n_cmp++; if (spo !== spf) begin n_fail++; $display("FAIL rand_%0d_sp: got %h want %h", k, spo, spf); end
            n_cmp++; if (perr != 0 || !pok || skips != int'(q[5])) begin n_fail++; $display("FAIL rand_%0d_protocol: perr %0d post_ok %0d skips %0d want 0 1 %0d", k, perr, pok, skips, q[5]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.push_mask = '0; bus.pop_mask = '0;
        bus.sp_in = '0; bus.req_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_push();
        test_pop();
        test_skip();
        test_backpressure();
        test_combined();
        test_empty_and_wrap();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
